// File: rtl/alarm_multi_ctrl.sv
// Multi-channel hh:mm alarm sequencer: per-channel compare on minute edges, pending queue
// serviced lowest index first, ring/snooze timing on sec_tick, sticky missed flags.
module alarm_multi_ctrl #(
  parameter int N_ALARMS   = 4,
  parameter int SNOOZE_SEC = 300,
  parameter int RING_SEC   = 60,
  parameter int MAX_SNOOZE = 3,
  localparam int IDXW = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                sec_tick,
  input  logic                master_en,
  input  logic [15:0]         time_now,
  input  logic                wr_en,
  input  logic [IDXW-1:0]     wr_idx,
  input  logic [15:0]         wr_time,
  input  logic                wr_arm,
  input  logic                snooze_btn,
  input  logic                stop_btn,
  output logic                aud_en,
  output logic [1:0]          state_o,
  output logic [IDXW-1:0]     active_idx,
  output logic [N_ALARMS-1:0] pending_o,
  output logic [N_ALARMS-1:0] missed_o
);

  localparam int RTW = $clog2(RING_SEC + 1);
  localparam int STW = $clog2(SNOOZE_SEC + 1);
  localparam int SCW = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZED = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [15:0]         alarm_time_reg [N_ALARMS];
  logic [N_ALARMS-1:0] armed_reg;
  logic [15:0]         time_q_reg;
  logic [N_ALARMS-1:0] pending_reg, pending_next;
  logic [N_ALARMS-1:0] missed_reg, missed_next;
  logic [IDXW-1:0]     active_idx_reg, active_idx_next;
  logic [SCW-1:0]      snooze_cnt_reg, snooze_cnt_next;
  logic [RTW-1:0]      ring_timer_reg, ring_timer_next;
  logic [STW-1:0]      snooze_timer_reg, snooze_timer_next;

  logic                minute_edge;
  logic                wr_valid;
  logic                act_disarm;
  logic                ring_done;
  logic                snooze_done;
  logic [N_ALARMS-1:0] trig;
  logic [N_ALARMS-1:0] wr_hit;
  logic [N_ALARMS-1:0] take_mask;
  logic [N_ALARMS-1:0] missed_set;
  logic [IDXW-1:0]     low_idx;

  assign minute_edge = (time_now != time_q_reg);
  assign wr_valid    = wr_en && (int'(wr_idx) < N_ALARMS);
  assign act_disarm  = wr_valid && !wr_arm && (wr_idx == active_idx_reg);
  assign ring_done   = sec_tick && (ring_timer_reg >= RTW'(RING_SEC - 1));
  assign snooze_done = sec_tick && (snooze_timer_reg >= STW'(SNOOZE_SEC - 1));

  genvar gi;
  generate
    for (gi = 0; gi < N_ALARMS; gi++) begin : g_ch
      assign wr_hit[gi] = wr_valid && (wr_idx == IDXW'(gi));
      // Compare against the registered alarm so a same-cycle write never fires this minute.
      assign trig[gi]   = minute_edge && master_en && armed_reg[gi] &&
                          (alarm_time_reg[gi] == time_now);

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          alarm_time_reg[gi] <= '0;
          armed_reg[gi]      <= 1'b0;
        end else if (wr_hit[gi]) begin
          alarm_time_reg[gi] <= wr_time;
          armed_reg[gi]      <= wr_arm;
        end
      end
    end
  endgenerate

  always_comb begin
    low_idx = '0;
    for (int i = N_ALARMS - 1; i >= 0; i--) begin
      if (pending_reg[i]) low_idx = IDXW'(i);
    end
  end

  always_comb begin
    state_next        = state_reg;
    active_idx_next   = active_idx_reg;
    snooze_cnt_next   = snooze_cnt_reg;
    ring_timer_next   = ring_timer_reg;
    snooze_timer_next = snooze_timer_reg;
    take_mask         = '0;
    missed_set        = '0;

    if (!master_en) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pending_reg != '0) begin
            state_next         = RINGING;
            active_idx_next    = low_idx;
            snooze_cnt_next    = '0;
            ring_timer_next    = '0;
            take_mask[low_idx] = 1'b1;
          end
        end
        RINGING: begin
          if (sec_tick && ring_timer_reg != RTW'(RING_SEC))
            ring_timer_next = ring_timer_reg + RTW'(1);
          if (act_disarm || stop_btn) begin
            state_next = IDLE;
          end else if (ring_done) begin
            state_next                 = IDLE;
            missed_set[active_idx_reg] = 1'b1;
          end else if (snooze_btn) begin
            if (snooze_cnt_reg < SCW'(MAX_SNOOZE)) begin
              state_next        = SNOOZED;
              snooze_cnt_next   = snooze_cnt_reg + SCW'(1);
              snooze_timer_next = '0;
            end else begin
              state_next = IDLE;
            end
          end
        end
        SNOOZED: begin
          if (sec_tick && snooze_timer_reg != STW'(SNOOZE_SEC))
            snooze_timer_next = snooze_timer_reg + STW'(1);
          if (act_disarm || stop_btn) begin
            state_next = IDLE;
          end else if (snooze_done) begin
            state_next      = RINGING;
            ring_timer_next = '0;
          end
        end
        default: state_next = IDLE;
      endcase
    end

    // A write to a channel wipes its queue entry and missed flag, even against a same-cycle event.
    pending_next = master_en ? ((pending_reg | trig) & ~take_mask & ~wr_hit) : '0;
    missed_next  = (missed_reg | missed_set) & ~wr_hit;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg        <= IDLE;
      time_q_reg       <= '0;
      pending_reg      <= '0;
      missed_reg       <= '0;
      active_idx_reg   <= '0;
      snooze_cnt_reg   <= '0;
      ring_timer_reg   <= '0;
      snooze_timer_reg <= '0;
    end else begin
      state_reg        <= state_next;
      time_q_reg       <= time_now;
      pending_reg      <= pending_next;
      missed_reg       <= missed_next;
      active_idx_reg   <= active_idx_next;
      snooze_cnt_reg   <= snooze_cnt_next;
      ring_timer_reg   <= ring_timer_next;
      snooze_timer_reg <= snooze_timer_next;
    end
  end

  assign aud_en     = (state_reg == RINGING);
  assign state_o    = state_reg;
  assign active_idx = active_idx_reg;
  assign pending_o  = pending_reg;
  assign missed_o   = missed_reg;

endmodule

// File: tb/tb_alarm_multi_ctrl.sv
// Directed bench for alarm_multi_ctrl with short timers (SNOOZE_SEC=3, RING_SEC=4, MAX_SNOOZE=1).
module tb_alarm_multi_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        sec_tick, master_en, wr_en, wr_arm, snooze_btn, stop_btn;
  logic [15:0] time_now, wr_time;
  logic [1:0]  wr_idx;
  logic        aud_en;
  logic [1:0]  state_o;
  logic [1:0]  active_idx;
  logic [3:0]  pending_o, missed_o;

  always #5 clk = ~clk;

  alarm_multi_ctrl #(
    .N_ALARMS(4), .SNOOZE_SEC(3), .RING_SEC(4), .MAX_SNOOZE(1)
  ) dut (
    .clk(clk), .rstn(rstn), .sec_tick(sec_tick), .master_en(master_en),
    .time_now(time_now), .wr_en(wr_en), .wr_idx(wr_idx), .wr_time(wr_time),
    .wr_arm(wr_arm), .snooze_btn(snooze_btn), .stop_btn(stop_btn),
    .aud_en(aud_en), .state_o(state_o), .active_idx(active_idx),
    .pending_o(pending_o), .missed_o(missed_o)
  );

  typedef struct {
    logic [15:0] t;
    logic        me;
    logic        wr;
    logic [1:0]  widx;
    logic [15:0] wtime;
    logic        warm;
    logic        snz;
    logic        stp;
    logic        tick;
    logic [1:0]  e_state;
    logic [1:0]  e_idx;
    logic [3:0]  e_pend;
    logic [3:0]  e_miss;
  } vec_t;

  vec_t vecs [64];
  int   nv    = 0;
  int   total = 0;
  int   bad   = 0;

  task automatic add(input logic [15:0] t, input logic me, input logic wr, input logic [1:0] widx,
                     input logic [15:0] wtime, input logic warm, input logic snz, input logic stp,
                     input logic tick, input logic [1:0] es, input logic [1:0] ei,
                     input logic [3:0] ep, input logic [3:0] em);
    vecs[nv].t = t;       vecs[nv].me = me;       vecs[nv].wr = wr;
    vecs[nv].widx = widx; vecs[nv].wtime = wtime; vecs[nv].warm = warm;
    vecs[nv].snz = snz;   vecs[nv].stp = stp;     vecs[nv].tick = tick;
    vecs[nv].e_state = es; vecs[nv].e_idx = ei;
    vecs[nv].e_pend = ep;  vecs[nv].e_miss = em;
    nv++;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] t, input logic me, input logic wr, input logic [1:0] widx,
                       input logic [15:0] wtime, input logic warm, input logic snz,
                       input logic stp, input logic tick);
    time_now = t; master_en = me; wr_en = wr; wr_idx = widx; wr_time = wtime;
    wr_arm = warm; snooze_btn = snz; stop_btn = stp; sec_tick = tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic [1:0] es, input logic [1:0] ei,
                          input logic [3:0] ep, input logic [3:0] em);
    chk({tag, ".state"}, 16'(state_o), 16'(es));
    chk({tag, ".aud"}, 16'(aud_en), 16'(es == 2'd1));
    chk({tag, ".pend"}, 16'(pending_o), 16'(ep));
    chk({tag, ".miss"}, 16'(missed_o), 16'(em));
    if (es != 2'd0) chk({tag, ".idx"}, 16'(active_idx), 16'(ei));
  endtask

  initial begin
    rstn = 1'b0;
    time_now = '0; master_en = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_time = '0;
    wr_arm = 1'b0; snooze_btn = 1'b0; stop_btn = 1'b0; sec_tick = 1'b0;

    //    t        me wr idx wtime    arm snz stp tk   st idx pend     miss
    add(16'h0729, 1, 1, 0, 16'h0730, 1,  0,  0,  0,  0, 0, 4'b0000, 4'b0000); // arm ch0
    add(16'h0729, 1, 0, 0, 16'h0000, 0,  0,  0,  0,  0, 0, 4'b0000, 4'b0000);
    add(16'h0730, 1, 0, 0, 16'h0000, 0,  0,  0,  0,  0, 0, 4'b0001, 4'b0000); // edge T
    add(16'h0730, 1, 0, 0, 16'h0000, 0,  0,  0,  0,  1, 0, 4'b0000, 4'b0000); // ring T+2
    add(16'h0730, 1, 0, 0, 16'h0000, 0,  1,  0,  0,  2, 0, 4'b0000, 4'b0000); // snooze
    add(16'h0730, 1, 0, 0, 16'h0000, 0,  0,  0,  1,  2, 0, 4'b0000, 4'b0000);
    add(16'h0730, 1, 0, 0, 16'h0000, 0,  0,  0,  1,  2, 0, 4'b0000, 4'b0000);
    add(16'h0730, 1, 0, 0, 16'h0000, 0,  0,  0,  1,  1, 0, 4'b0000, 4'b0000); // 3rd tick
    add(16'h0730, 1, 0, 0, 16'h0000, 0,  1,  0,  0,  0, 0, 4'b0000, 4'b0000); // over limit
    add(16'h0731, 1, 0, 0, 16'h0000, 0,  0,  0,  0,  0, 0, 4'b0000, 4'b0000);
    add(16'h0730, 1, 0, 0, 16'h0000, 0,  0,  0,  0,  0, 0, 4'b0001, 4'b0000);
    add(16'h0730, 1, 0, 0, 16'h0000, 0,  0,  0,  0,  1, 0, 4'b0000, 4'b0000);
    add(16'h0730, 1, 0, 0, 16'h0000, 0,  0,  0,  1,  1, 0, 4'b0000, 4'b0000);
    add(16'h0730, 1, 0, 0, 16'h0000, 0,  0,  0,  1,  1, 0, 4'b0000, 4'b0000);
    add(16'h0730, 1, 0, 0, 16'h0000, 0,  0,  0,  1,  1, 0, 4'b0000, 4'b0000);
    add(16'h0730, 1, 0, 0, 16'h0000, 0,  0,  0,  1,  0, 0, 4'b0000, 4'b0001); // timeout
    add(16'h0730, 1, 1, 0, 16'h0730, 1,  0,  0,  0,  0, 0, 4'b0000, 4'b0000); // rewrite ch0
    add(16'h0730, 1, 1, 1, 16'h0800, 1,  0,  0,  0,  0, 0, 4'b0000, 4'b0000);
    add(16'h0730, 1, 1, 3, 16'h0800, 1,  0,  0,  0,  0, 0, 4'b0000, 4'b0000);
    add(16'h0800, 1, 0, 0, 16'h0000, 0,  0,  0,  0,  0, 0, 4'b1010, 4'b0000);
    add(16'h0800, 1, 0, 0, 16'h0000, 0,  0,  0,  0,  1, 1, 4'b1000, 4'b0000);
    add(16'h0800, 1, 0, 0, 16'h0000, 0,  0,  1,  0,  0, 0, 4'b1000, 4'b0000); // stop
    add(16'h0800, 1, 0, 0, 16'h0000, 0,  0,  0,  0,  1, 3, 4'b0000, 4'b0000);
    add(16'h0800, 1, 0, 0, 16'h0000, 0,  1,  1,  0,  0, 0, 4'b0000, 4'b0000); // stop+snooze
    add(16'h0801, 1, 0, 0, 16'h0000, 0,  0,  0,  0,  0, 0, 4'b0000, 4'b0000);
    add(16'h0800, 1, 0, 0, 16'h0000, 0,  0,  0,  0,  0, 0, 4'b1010, 4'b0000);
    add(16'h0800, 1, 0, 0, 16'h0000, 0,  0,  0,  0,  1, 1, 4'b1000, 4'b0000);
    add(16'h0800, 0, 0, 0, 16'h0000, 0,  0,  0,  0,  0, 0, 4'b0000, 4'b0000); // master off
    add(16'h0801, 0, 0, 0, 16'h0000, 0,  0,  0,  0,  0, 0, 4'b0000, 4'b0000);
    add(16'h0800, 0, 0, 0, 16'h0000, 0,  0,  0,  0,  0, 0, 4'b0000, 4'b0000);
    add(16'h0800, 1, 0, 0, 16'h0000, 0,  0,  0,  0,  0, 0, 4'b0000, 4'b0000); // no edge
    add(16'h0800, 1, 1, 2, 16'h0800, 1,  0,  0,  0,  0, 0, 4'b0000, 4'b0000); // mid-minute
    add(16'h0800, 1, 0, 0, 16'h0000, 0,  0,  0,  0,  0, 0, 4'b0000, 4'b0000);
    add(16'h0801, 1, 0, 0, 16'h0000, 0,  0,  0,  0,  0, 0, 4'b0000, 4'b0000);
    add(16'h0800, 1, 0, 0, 16'h0000, 0,  0,  0,  0,  0, 0, 4'b1110, 4'b0000);
    add(16'h0800, 1, 0, 0, 16'h0000, 0,  0,  0,  0,  1, 1, 4'b1100, 4'b0000);
    add(16'h0800, 1, 1, 1, 16'h0800, 0,  0,  0,  0,  0, 0, 4'b1100, 4'b0000); // disarm active
    add(16'h0800, 1, 0, 0, 16'h0000, 0,  0,  0,  0,  1, 2, 4'b1000, 4'b0000);
    add(16'h0800, 1, 1, 2, 16'h0900, 1,  0,  0,  0,  1, 2, 4'b1000, 4'b0000); // re-time active
    add(16'h0800, 1, 0, 0, 16'h0000, 0,  0,  1,  0,  0, 0, 4'b1000, 4'b0000);
    add(16'h0800, 1, 0, 0, 16'h0000, 0,  0,  0,  0,  1, 3, 4'b0000, 4'b0000);
    add(16'h0800, 1, 0, 0, 16'h0000, 0,  0,  0,  1,  1, 3, 4'b0000, 4'b0000);
    add(16'h0800, 1, 0, 0, 16'h0000, 0,  0,  0,  1,  1, 3, 4'b0000, 4'b0000);
    add(16'h0800, 1, 0, 0, 16'h0000, 0,  0,  0,  1,  1, 3, 4'b0000, 4'b0000);
    add(16'h0800, 1, 0, 0, 16'h0000, 0,  0,  0,  1,  0, 0, 4'b0000, 4'b1000);
    add(16'h0800, 0, 0, 0, 16'h0000, 0,  0,  0,  0,  0, 0, 4'b0000, 4'b1000); // missed kept
    add(16'h0800, 1, 0, 0, 16'h0000, 0,  0,  0,  0,  0, 0, 4'b0000, 4'b1000);

    repeat (2) @(posedge clk);
    #1;
    chk_outs("reset", 2'd0, 2'd0, 4'b0000, 4'b0000);
    chk("reset.idx", 16'(active_idx), 16'h0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < nv; i++) begin
      drive(vecs[i].t, vecs[i].me, vecs[i].wr, vecs[i].widx, vecs[i].wtime, vecs[i].warm,
            vecs[i].snz, vecs[i].stp, vecs[i].tick);
      $display("vec %0d: t=%h state=%0d idx=%0d pend=%b miss=%b", i, time_now, state_o,
               active_idx, pending_o, missed_o);
      chk_outs($sformatf("vec%0d", i), vecs[i].e_state, vecs[i].e_idx, vecs[i].e_pend,
               vecs[i].e_miss);
    end

    // Reset asserted mid-ring clears outputs without waiting for a clock edge.
    drive(16'h0730, 1, 0, 0, 16'h0000, 0, 0, 0, 0);
    drive(16'h0730, 1, 0, 0, 16'h0000, 0, 0, 0, 0);
    $display("pre-reset: state=%0d idx=%0d miss=%b", state_o, active_idx, missed_o);
    chk_outs("prerst", 2'd1, 2'd0, 4'b0000, 4'b1000);
    #1;
    rstn = 1'b0;
    #1;
    $display("async reset: state=%0d aud=%0d pend=%b miss=%b", state_o, aud_en, pending_o, missed_o);
    chk_outs("asyncrst", 2'd0, 2'd0, 4'b0000, 4'b0000);
    chk("asyncrst.idx", 16'(active_idx), 16'h0);
    @(negedge clk);
    rstn = 1'b1;

    // All channels are disarmed after reset: no alarm time may trigger.
    drive(16'h0731, 1, 0, 0, 16'h0000, 0, 0, 0, 0);
    drive(16'h0730, 1, 0, 0, 16'h0000, 0, 0, 0, 0);
    drive(16'h0800, 1, 0, 0, 16'h0000, 0, 0, 0, 0);
    drive(16'h0800, 1, 0, 0, 16'h0000, 0, 0, 0, 0);
    $display("post-reset: state=%0d pend=%b miss=%b", state_o, pending_o, missed_o);
    chk_outs("postrst", 2'd0, 2'd0, 4'b0000, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
